// File: rtl/router_fsm.sv
// router_fsm -- control FSM for the 1x3 router.
//
// Decodes the header address of each incoming packet. It also sequences the
// register block through its first-data, load, full-hold and parity phases.
//
// Ports:
//   clock          system clock, all logic on the rising edge
//   reset          synchronous active-high reset
//   pkt_valid      source presents a valid byte
//   data_in        header address bits (bus bits [1:0])
//   fifo_full      currently selected FIFO is full
//   fifo_empty     per-FIFO empty flags
//   soft_reset     per-FIFO read-timeout soft reset
//   parity_done    register block has captured parity
//   low_pkt_valid  register block saw pkt_valid fall
//   detect_add / lfd_state / ld_state / laf_state / full_state / rst_int_reg
//                  one-hot state strobes to the register block
//   write_enb_reg  FIFO write strobe
//   busy           source must hold its current byte
//   port_sel       latched destination address
//   pkt_drop       one-cycle pulse when a header with an invalid address is discarded
module router_fsm #(
  parameter int unsigned NUM_PORTS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [1:0]           data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [1:0]           port_sel,
  output logic                 pkt_drop
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] port_sel_q;
  logic       pkt_drop_q;

  // The 2-bit address can name four ports. Pad the per-port flags to four
  // entries so that indexing with any address stays in range. Ports that do
  // not exist read as "not empty" and "no soft reset".
  logic [3:0] empty_pad;
  logic [3:0] soft_pad;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_PORTS) begin : g_real
        assign empty_pad[gi] = fifo_empty[gi];
        assign soft_pad[gi]  = soft_reset[gi];
      end else begin : g_none
        assign empty_pad[gi] = 1'b0;
        assign soft_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  logic addr_valid;
  logic soft_hit;

  assign addr_valid = (32'(data_in) < NUM_PORTS);
  // A soft reset only matters once a destination has been committed to.
  assign soft_hit   = soft_pad[port_sel_q] && (state_q != DECODE_ADDRESS);

  always_comb begin
    state_d = state_q;
    if (soft_hit) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_valid) begin
            state_d = empty_pad[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_pad[port_sel_q]) state_d = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          // A full FIFO wins over end-of-packet so the parity byte is not lost.
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DECODE_ADDRESS;
      port_sel_q <= 2'd0;
      pkt_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_drop_q <= (state_q == DECODE_ADDRESS) && pkt_valid && !addr_valid;
      if ((state_q == DECODE_ADDRESS) && pkt_valid && addr_valid) begin
        port_sel_q <= data_in;
      end
    end
  end

  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = ld_state || laf_state || (state_q == LOAD_PARITY);
  assign busy          = !(detect_add || ld_state);
  assign port_sel      = port_sel_q;
  assign pkt_drop      = pkt_drop_q;

endmodule

// File: tb/tb_router_fsm.sv
// Testbench for router_fsm. It runs the directed packet scenarios first and
// then a stretch of random traffic. A reference model inside the bench
// predicts every output on every clock.
module tb_router_fsm;

  localparam int NP = 3;

  // Phase names the reference model uses for its own bookkeeping.
  localparam int P_DECODE = 0, P_LFD = 1, P_LD = 2, P_WAIT = 3,
                 P_FULL = 4, P_LAF = 5, P_PAR = 6, P_CHK = 7;

  logic          clock = 1'b0;
  logic          reset, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0]    data_in;
  logic [NP-1:0] fifo_empty, soft_reset;
  logic          detect_add, lfd_state, ld_state, laf_state, full_state;
  logic          rst_int_reg, write_enb_reg, busy, pkt_drop;
  logic [1:0]    port_sel;

  int errors = 0;
  int checks = 0;

  int         m_phase;
  logic [1:0] m_port;
  logic       m_drop;

  router_fsm #(.NUM_PORTS(NP)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .port_sel(port_sel),
    .pkt_drop(pkt_drop)
  );

  always #5 clock = ~clock;

  // Expected output vector:
  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy, port_sel[1:0], pkt_drop}
  function automatic logic [10:0] expect_outs(int ph, logic [1:0] port, logic drop);
    logic writing, holding;
    writing = (ph == P_LD) || (ph == P_PAR) || (ph == P_LAF);
    holding = !((ph == P_DECODE) || (ph == P_LD));
    return {ph == P_DECODE, ph == P_LFD, ph == P_LD, ph == P_LAF, ph == P_FULL,
            ph == P_CHK, writing, holding, port, drop};
  endfunction

  function automatic logic [10:0] observed();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
            write_enb_reg, busy, port_sel, pkt_drop};
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_tick();
    int nxt;
    bool_block: begin
      if (reset) begin
        m_phase = P_DECODE;
        m_port  = 2'd0;
        m_drop  = 1'b0;
        disable bool_block;
      end
      nxt    = m_phase;
      m_drop = (m_phase == P_DECODE) && pkt_valid && (int'(data_in) >= NP);
      if (m_phase != P_DECODE && soft_reset[m_port]) begin
        nxt = P_DECODE;
      end else if (m_phase == P_DECODE) begin
        if (pkt_valid && int'(data_in) < NP)
          nxt = fifo_empty[data_in] ? P_LFD : P_WAIT;
      end else if (m_phase == P_WAIT) begin
        if (fifo_empty[m_port]) nxt = P_LFD;
      end else if (m_phase == P_LFD) begin
        nxt = P_LD;
      end else if (m_phase == P_LD) begin
        if (fifo_full) nxt = P_FULL;
        else if (!pkt_valid) nxt = P_PAR;
      end else if (m_phase == P_FULL) begin
        if (!fifo_full) nxt = P_LAF;
      end else if (m_phase == P_LAF) begin
        nxt = parity_done ? P_DECODE : (low_pkt_valid ? P_PAR : P_LD);
      end else if (m_phase == P_PAR) begin
        nxt = P_CHK;
      end else begin
        nxt = fifo_full ? P_FULL : P_DECODE;
      end
      if (m_phase == P_DECODE && pkt_valid && int'(data_in) < NP) m_port = data_in;
      m_phase = nxt;
    end
  endtask

  task automatic check_vec(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, clock, then compare all outputs to the model.
  task automatic step(input string tag, input logic rst, input logic pv,
                      input logic [1:0] din, input logic full, input logic [NP-1:0] empty,
                      input logic [NP-1:0] sr, input logic pd, input logic lpv);
    reset = rst; pkt_valid = pv; data_in = din; fifo_full = full;
    fifo_empty = empty; soft_reset = sr; parity_done = pd; low_pkt_valid = lpv;
    model_tick();
    @(posedge clock);
    #1;
    $display("%-10s rst=%b pv=%b din=%0d full=%b empty=%b sr=%b pd=%b lpv=%b -> out=%b",
             tag, rst, pv, din, full, empty, sr, pd, lpv, observed());
    check_vec(tag, observed(), expect_outs(m_phase, m_port, m_drop));
  endtask

  int wr_cycles;
  int rst_int_cycles;

  initial begin
    m_phase = P_DECODE; m_port = 2'd0; m_drop = 1'b0;

    // Reset for two cycles.
    step("reset", 1, 0, 0, 0, 3'b111, 0, 0, 0);
    step("reset", 1, 1, 2, 1, 3'b000, 0, 0, 0);
    check_bit("rst_detect", detect_add, 1'b1);
    check_bit("rst_busy", busy, 1'b0);

    // 1: normal packet to port 1, three payload bytes then parity.
    wr_cycles = 0;
    step("hdr_p1", 0, 1, 1, 0, 3'b111, 0, 0, 0);
    wr_cycles += int'(write_enb_reg);
    for (int i = 0; i < 3; i++) begin
      step("payload", 0, 1, 0, 0, 3'b111, 0, 0, 0);
      wr_cycles += int'(write_enb_reg);
    end
    step("parity", 0, 0, 0, 0, 3'b111, 0, 0, 0);
    wr_cycles += int'(write_enb_reg);
    step("chk_par", 0, 0, 0, 0, 3'b111, 0, 0, 0);
    wr_cycles += int'(write_enb_reg);
    step("to_dec", 0, 0, 0, 0, 3'b111, 0, 0, 0);
    check_bit("pkt1_port", port_sel == 2'd1, 1'b1);
    check_bit("pkt1_wr4", wr_cycles == 4, 1'b1);

    // 2: destination 2 is busy for five cycles.
    step("hdr_p2", 0, 1, 2, 0, 3'b011, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("wait", 0, 1, 2, 0, 3'b011, 0, 0, 0);
    check_bit("wait_busy", busy, 1'b1);
    step("empty", 0, 1, 2, 0, 3'b111, 0, 0, 0);
    check_bit("wait_to_lfd", lfd_state, 1'b1);
    step("ld", 0, 1, 0, 0, 3'b111, 0, 0, 0);

    // 3: FIFO full mid-packet for three cycles.
    for (int i = 0; i < 3; i++) step("full", 0, 1, 0, 1, 3'b111, 0, 0, 0);
    check_bit("full_hold", full_state, 1'b1);
    step("unfull", 0, 1, 0, 0, 3'b111, 0, 0, 0);
    step("laf_ld", 0, 1, 0, 0, 3'b111, 0, 0, 0);
    check_bit("laf_to_ld", ld_state, 1'b1);

    // 4: FIFO full while checking parity.
    rst_int_cycles = 0;
    step("parity", 0, 0, 0, 0, 3'b111, 0, 0, 0);
    step("chk_par", 0, 0, 0, 1, 3'b111, 0, 0, 0);
    rst_int_cycles += int'(rst_int_reg);
    step("cpe_full", 0, 0, 0, 1, 3'b111, 0, 0, 0);
    rst_int_cycles += int'(rst_int_reg);
    step("full2", 0, 0, 0, 1, 3'b111, 0, 0, 0);
    rst_int_cycles += int'(rst_int_reg);
    step("unfull", 0, 0, 0, 0, 3'b111, 0, 0, 0);
    step("pdone", 0, 0, 0, 0, 3'b111, 0, 1, 0);
    check_bit("rst_int_once", rst_int_cycles == 1, 1'b1);

    // 5: invalid address is dropped, port_sel kept.
    step("bad_hdr", 0, 1, 3, 0, 3'b111, 0, 0, 0);
    check_bit("drop_pulse", pkt_drop, 1'b1);
    check_bit("drop_port", port_sel == 2'd2, 1'b1);
    step("idle", 0, 0, 3, 0, 3'b111, 0, 0, 0);
    check_bit("drop_clear", pkt_drop, 1'b0);

    // 6: soft reset in LOAD_DATA for port 0, then hard reset in FIFO_FULL_STATE.
    step("hdr_p0", 0, 1, 0, 0, 3'b111, 0, 0, 0);
    step("ld", 0, 1, 0, 0, 3'b111, 0, 0, 0);
    step("soft_rst", 0, 1, 0, 0, 3'b111, 3'b001, 0, 0);
    check_bit("soft_busy", busy, 1'b0);
    step("hdr_p1", 0, 1, 1, 0, 3'b111, 0, 0, 0);
    step("ld", 0, 1, 0, 0, 3'b111, 0, 0, 0);
    step("full", 0, 1, 0, 1, 3'b111, 0, 0, 0);
    step("hard_rst", 1, 1, 0, 1, 3'b111, 0, 0, 0);
    check_bit("hard_port0", port_sel == 2'd0, 1'b1);
    check_bit("hard_detect", detect_add, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name: router_fsm

Overview:
- Control FSM for the 1x3 router. Decodes the header address and sequences the register block through its load, full-hold and parity phases.
- Drives the register block's strobes: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg.
- Drives the synchronizer-facing write_enb_reg and the source-facing busy.
- Sits between the packet source, the register block and the three output FIFOs.

Parameters:
NUM_PORTS, 3, number of destination FIFOs; header addresses 0..NUM_PORTS-1 are valid, all others are dropped

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
pkt_valid  input  1  source has a valid byte on the bus
data_in  input  2  header address bits (bus bits [1:0])
fifo_full  input  1  selected FIFO is full
fifo_empty  input  NUM_PORTS  per-FIFO empty flags
soft_reset  input  NUM_PORTS  per-FIFO read-timeout soft reset
parity_done  input  1  register block has captured parity
low_pkt_valid  input  1  register block saw pkt_valid fall
detect_add  output  1  in DECODE_ADDRESS
lfd_state  output  1  in LOAD_FIRST_DATA
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
write_enb_reg  output  1  FIFO write strobe
busy  output  1  source must hold its byte
port_sel  output  2  latched destination address
pkt_drop  output  1  one-cycle pulse, header with invalid address discarded

Behaviour:
- Eight states: DECODE_ADDRESS (reset state), LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR. State register only; no other latency.
- Moore outputs, decoded combinationally from the state register:
  - detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg: one-hot per their states.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Reset:
  - state=DECODE_ADDRESS, so detect_add=1 and all other strobes, write_enb_reg and busy are 0.
  - port_sel=0, pkt_drop=0.
  - Reset overrides everything, including a reset asserted mid-packet.
- port_sel: loaded from data_in only in DECODE_ADDRESS with pkt_valid=1 and data_in<NUM_PORTS; held otherwise.
- Soft reset: if soft_reset[port_sel]=1 in any state other than DECODE_ADDRESS, the next state is DECODE_ADDRESS. This beats every normal transition.
- Transitions:
  - DECODE_ADDRESS:
    - pkt_valid, addr valid, fifo_empty[addr]=1 -> LOAD_FIRST_DATA.
    - pkt_valid, addr valid, fifo_empty[addr]=0 -> WAIT_TILL_EMPTY.
    - pkt_valid, addr>=NUM_PORTS -> stay; pkt_drop=1 next cycle.
    - otherwise -> stay.
  - WAIT_TILL_EMPTY: fifo_empty[port_sel] -> LOAD_FIRST_DATA, else stay.
  - LOAD_FIRST_DATA: -> LOAD_DATA unconditionally.
  - LOAD_DATA:
    - fifo_full -> FIFO_FULL_STATE; fifo_full has priority over pkt_valid=0.
    - else !pkt_valid -> LOAD_PARITY.
    - else stay.
  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL, else stay.
  - LOAD_AFTER_FULL:
    - parity_done -> DECODE_ADDRESS.
    - else low_pkt_valid -> LOAD_PARITY.
    - else -> LOAD_DATA.
  - LOAD_PARITY: -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE, else DECODE_ADDRESS.
- pkt_drop: registered; asserted exactly one cycle per rejected header. The source must drop pkt_valid for the dropped packet; the FSM does not track the dropped payload.
- Unreachable state encodings recover to DECODE_ADDRESS on the next clock.

Test Plan:
1. Normal packet:
   - Stimulus: reset 2 cycles; pkt_valid=1, data_in=2'b01, fifo_empty=3'b111; 3 payload bytes; pkt_valid=0 on the parity byte.
   - Required: states DECODE→LFD→LD×3→LOAD_PARITY→CHECK_PARITY_ERROR→DECODE. port_sel=1. write_enb_reg=1 for 4 cycles (3 payload bytes + parity; LFD excluded); busy=1 in LFD, LOAD_PARITY and CHECK_PARITY_ERROR only.
2. Busy destination:
   - Stimulus: data_in=2'b10, fifo_empty=3'b011 for 5 cycles, then 3'b111.
   - Required: WAIT_TILL_EMPTY held 5 cycles with busy=1 and write_enb_reg=0, then LFD.
3. Full mid-packet:
   - Stimulus: fifo_full=1 for 3 cycles while in LOAD_DATA with pkt_valid=1.
   - Required: FIFO_FULL_STATE for 3 cycles (full_state=1, write_enb_reg=0), then LAF; with parity_done=0 and low_pkt_valid=0, next LOAD_DATA.
4. Full on parity:
   - Stimulus: fifo_full=1 in CHECK_PARITY_ERROR; release after 2 cycles; parity_done=1 in LAF.
   - Required: CPE→FFS×2→LAF→DECODE; rst_int_reg=1 for exactly 1 cycle.
5. Invalid address:
   - Stimulus: pkt_valid=1, data_in=2'b11.
   - Required: stays in DECODE_ADDRESS, port_sel unchanged, pkt_drop=1 for one cycle.
6. Soft reset and hard reset:
   - Stimulus: soft_reset=3'b001 while in LOAD_DATA for port 0; separately, reset=1 in FIFO_FULL_STATE.
   - Required: next state DECODE_ADDRESS with detect_add=1 and busy=0 in both cases; after hard reset, port_sel=0.
